// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage fed by the SPI register file; one shared 8-bit PWM waveform.
// Optional macro PWM_SYNC_UPDATE_EN: duty is double-buffered and only reloaded at the period wrap.
`timescale 1ns/1ps
module pwm_peripheral #(
  parameter int CLK_DIV = 13,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_out_lo,
  input  logic [7:0]  en_out_hi,
  input  logic [7:0]  en_pwm_lo,
  input  logic [7:0]  en_pwm_hi,
  input  logic [7:0]  duty,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] prescaler;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_eff;
  logic             tick;
  logic             wrap;
  logic             pwm_raw;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      out_next;

  assign en_out = {en_out_hi, en_out_lo};
  assign en_pwm = {en_pwm_hi, en_pwm_lo};
  assign tick   = (prescaler == DIV_LAST);
  assign wrap   = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= 8'd0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
        prescaler <= prescaler + DIV_W'(1);
      end
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  // Shadow reloads on the same edge the counter rolls over, so a period never sees two duty values.
  logic [7:0] duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= 8'd0;
    end else if (wrap) begin
      duty_shadow <= duty;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = duty;
`endif

  // Code 255 is forced to a solid high so full-scale has no one-step dip at the wrap.
  assign pwm_raw  = (duty_eff == 8'hFF) || (pwm_cnt < duty_eff);
  assign out_next = en_out & (~en_pwm | {16{pwm_raw}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed self-checking bench for pwm_peripheral (CLK_DIV=13 and CLK_DIV=1 instances).
// Expected values depend on whether PWM_SYNC_UPDATE_EN is defined.
`timescale 1ns/1ps
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [15:0] out;
  logic        period_start;
  logic [7:0]  duty_fast;
  logic [15:0] out_fast;
  logic        period_start_fast;

  int checks = 0;
  int failures = 0;

`ifdef PWM_SYNC_UPDATE_EN
  localparam int          T4_W1_HIGH = 832;
  localparam logic [15:0] T4_AFTER   = 16'h0000;
  localparam int          T5_HIGH    = 0;
  localparam logic [15:0] T5_FIRST   = 16'h0000;
`else
  localparam int          T4_W1_HIGH = 2028;
  localparam logic [15:0] T4_AFTER   = 16'hFFFF;
  localparam int          T5_HIGH    = 3250;
  localparam logic [15:0] T5_FIRST   = 16'hFFFF;
`endif

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(13), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .en_out_lo(en_out_lo), .en_out_hi(en_out_hi),
    .en_pwm_lo(en_pwm_lo), .en_pwm_hi(en_pwm_hi),
    .duty(duty), .out(out), .period_start(period_start)
  );

  pwm_peripheral #(.CLK_DIV(1), .DIV_W(16)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .en_out_lo(8'hFF), .en_out_hi(8'hFF),
    .en_pwm_lo(8'hFF), .en_pwm_hi(8'hFF),
    .duty(duty_fast), .out(out_fast), .period_start(period_start_fast)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_out_hi, en_out_lo} = eo;
    {en_pwm_hi, en_pwm_lo} = ep;
    duty = d;
  endtask

  task automatic waitPeriodStart(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 4000);
    checkOutput(tag, 32'(period_start), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k, hi, lo, bad, rises, ps_at;
    logic prev;

    // Test 1: reset state, static outputs, period_start timing
    applyStimulus(16'hFFFF, 16'h0000, 8'd0);
    duty_fast = 8'd3;
    repeat (3) @(negedge clk);
    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_ps", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1_out_static", 32'(out), 32'hFFFF);
    k = 1;
    while (!period_start && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t1_first_ps_cycle", 32'(k), 32'd3328);
    @(negedge clk);
    checkOutput("t1_ps_one_cycle", 32'(period_start), 32'd0);
    k = 1;
    while (!period_start && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t1_ps_interval", 32'(k), 32'd3328);

    // Test 2: mixed static / PWM / disabled pins at duty 128
    applyStimulus(16'h00FF, 16'h000F, 8'd128);
    @(negedge clk);
    checkOutput("t2_enable_next_edge", 32'(out[15:4]), 32'h00F);
    waitPeriodStart("t2_sync");
    hi = 0; lo = 0; bad = 0; rises = 0;
    prev = out[0];
    for (int j = 1; j <= 3328; j++) begin
      @(negedge clk);
      if (out[3:0] == 4'hF) hi++;
      else if (out[3:0] == 4'h0) lo++;
      if (out[15:4] != 12'h00F) bad++;
      if (out[0] && !prev) rises++;
      prev = out[0];
    end
    checkOutput("t2_high", 32'(hi), 32'd1664);
    checkOutput("t2_low", 32'(lo), 32'd1664);
    checkOutput("t2_static_pins_bad", 32'(bad), 32'd0);
    checkOutput("t2_rises", 32'(rises), 32'd1);

    // Test 3: duty 0 and 255 across two full periods each
    applyStimulus(16'hFFFF, 16'hFFFF, 8'd0);
    waitPeriodStart("t3_sync0");
    bad = 0;
    for (int j = 0; j < 6656; j++) begin
      @(negedge clk);
      if (out != 16'h0000) bad++;
    end
    checkOutput("t3_duty0_bad", 32'(bad), 32'd0);
    applyStimulus(16'hFFFF, 16'hFFFF, 8'd255);
    waitPeriodStart("t3_sync255");
    bad = 0;
    for (int j = 0; j < 6656; j++) begin
      @(negedge clk);
      if (out != 16'hFFFF) bad++;
    end
    checkOutput("t3_duty255_bad", 32'(bad), 32'd0);

    // Test 4: duty 64 -> 192 at pwm_cnt=100
    applyStimulus(16'hFFFF, 16'hFFFF, 8'd64);
    waitPeriodStart("t4_sync");
    hi = 0;
    for (int j = 1; j <= 3328; j++) begin
      @(negedge clk);
      if (out == 16'hFFFF) hi++;
      if (j == 1301) checkOutput("t4_after_change", 32'(out), 32'(T4_AFTER));
      if (j == 1300) duty = 8'd192;
    end
    checkOutput("t4_window1_high", 32'(hi), 32'(T4_W1_HIGH));
    hi = 0;
    for (int j = 1; j <= 3328; j++) begin
      @(negedge clk);
      if (out == 16'hFFFF) hi++;
    end
    checkOutput("t4_window2_high", 32'(hi), 32'd2496);
    checkOutput("t4_ps_aligned", 32'(period_start), 32'd1);

    // Test 5: asynchronous reset mid-period at pwm_cnt=200
    applyStimulus(16'hFFFF, 16'hFFFF, 8'd250);
    waitPeriodStart("t5_sync");
    repeat (2600) @(negedge clk);
    checkOutput("t5_out_before_reset", 32'(out), 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_async_out", 32'(out), 32'h0);
    checkOutput("t5_async_ps", 32'(period_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0; ps_at = 0;
    for (int j = 1; j <= 3328; j++) begin
      @(negedge clk);
      if (j == 1) checkOutput("t5_fresh_first", 32'(out), 32'(T5_FIRST));
      if (out == 16'hFFFF) hi++;
      if (period_start && ps_at == 0) ps_at = j;
    end
    checkOutput("t5_fresh_high", 32'(hi), 32'(T5_HIGH));
    checkOutput("t5_fresh_ps_at", 32'(ps_at), 32'd3328);

    // Test 6: CLK_DIV=1 instance at duty 3
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start_fast && k < 600);
    checkOutput("t6_sync", 32'(period_start_fast), 32'd1);
    hi = 0;
    for (int j = 1; j <= 256; j++) begin
      @(negedge clk);
      if (out_fast == 16'hFFFF) hi++;
      if (j == 1) checkOutput("t6_first_high", 32'(out_fast), 32'hFFFF);
      if (j == 4) checkOutput("t6_fourth_low", 32'(out_fast), 32'h0);
      if (j == 255) checkOutput("t6_ps_low_before", 32'(period_start_fast), 32'd0);
    end
    checkOutput("t6_high", 32'(hi), 32'd3);
    checkOutput("t6_ps_interval", 32'(period_start_fast), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five 8-bit configuration registers written by the SPI register-file stage and drives 16 output pins.
- Each pin is individually enabled. An enabled pin is either static high or driven by one shared PWM waveform.
- The PWM waveform has 8-bit duty resolution and a period of about 3 kHz at a 10 MHz clk.
- Sits directly downstream of the SPI block. Its outputs go straight to chip pins.

Parameters:
- CLK_DIV, 13, prescaler divide ratio: one PWM count step every CLK_DIV clk cycles. Legal range 1..65535. Period = 256*CLK_DIV clk cycles.
- DIV_W, 16, prescaler counter width. Must satisfy 2**DIV_W >= CLK_DIV.

Ports:
- clk  in  1  system clock, same domain as SPI register outputs.
- rst_n  in  1  reset.
- en_out_lo  in  8  output enable, pins 7:0 (SPI reg1).
- en_out_hi  in  8  output enable, pins 15:8 (SPI reg2).
- en_pwm_lo  in  8  PWM mode select, pins 7:0 (SPI reg3).
- en_pwm_hi  in  8  PWM mode select, pins 15:8 (SPI reg4).
- duty  in  8  duty cycle code 0..255 (SPI reg5).
- out  out  16  pin drive.
- period_start  out  1  one-cycle pulse marking PWM period boundary.

Interface decision: clock clk; reset rst_n, asynchronous, active-low.

Behaviour:
Reset (rst_n low, asynchronous):
- prescaler=0, pwm_cnt=0, duty_shadow=0, out=16'h0000, period_start=0.
- Applies immediately, including mid-period. The first clk edge after deassertion starts a fresh period at count 0.

Prescaler:
- Counts 0..CLK_DIV-1 and wraps.
- tick = (prescaler == CLK_DIV-1).
- CLK_DIV=1 means tick every cycle.

PWM counter:
- 8-bit pwm_cnt increments on tick and wraps 255->0.
- wrap = tick && pwm_cnt==255.

Compare (combinational), pwm_raw:
- pwm_raw = 1 if duty_eff==255.
- Otherwise pwm_raw = (pwm_cnt < duty_eff).
- duty 0 gives constant low. duty 255 gives constant high (100%, no glitch at wrap).
- Other values give high time of duty_eff*CLK_DIV cycles per period.

Per-pin select, i = 0..15, with en_out={en_out_hi,en_out_lo} and en_pwm={en_pwm_hi,en_pwm_lo}:
- en_out[i]=0: out[i]=0, regardless of en_pwm[i].
- en_out[i]=1, en_pwm[i]=0: out[i]=1.
- en_out[i]=1, en_pwm[i]=1: out[i]=pwm_raw.

Output timing:
- out is registered: one clk of latency from any input change or pwm_cnt change.
- Enable changes take effect on the next clk edge, mid-period allowed.

period_start:
- Registered as period_start <= wrap.
- High for exactly one clk, in the cycle pwm_cnt first holds 0 of a new period.
- Never high during reset, nor in the first period after reset.

Duty changes arriving mid-period are governed by the optional feature (duty_eff definition).

Inputs are assumed stable/synchronous to clk. The SPI stage guarantees this; no resynchronisers here.

Optional Feature:
Macro PWM_SYNC_UPDATE_EN.
- Defined: duty_eff = duty_shadow. duty_shadow loads duty only on wrap, at the same edge pwm_cnt goes 255->0.
  - A duty write mid-period is invisible until the next period; no runt or partial pulses.
  - Reset value is 0, so output is low in the first period after reset even if duty is nonzero.
- Undefined: duty_eff = duty directly; duty_shadow not implemented.
  - A duty change affects the compare on the next clk edge.
  - A mid-period change may shorten or lengthen the current high pulse.

Test Plan:
1. Reset release, CLK_DIV=13, en_out=16'hFFFF, en_pwm=0 -> out=16'hFFFF one clk after first edge; period_start first pulses at cycle 3328 after reset release, then every 3328 cycles.
2. en_out=16'h00FF, en_pwm=16'h000F, duty=128 -> pins 3:0 high 1664 / low 1664 cycles per period; pins 7:4 constant 1; pins 15:8 constant 0.
3. duty=0 then duty=255, all pins PWM-enabled -> out constant 16'h0000 across two full periods, then constant 16'hFFFF with no low cycle at any wrap.
4. Mid-period duty change 64->192 at pwm_cnt=100:
   - Macro defined: current period unchanged (high 832 cycles); next period high 2496 cycles.
   - Macro undefined: out goes high again within 1 clk after the change.
5. Assert rst_n low at pwm_cnt=200 with out high -> out=0 and period_start=0 immediately, without a clk edge; after release, out follows a fresh period from count 0.
6. CLK_DIV=1 instance, duty=3 -> out high for 3 clk, low for 253 clk; period_start every 256 clk.
